// File: rtl/fp8_pkg.sv
// Shared definitions for the FP8 (1-3-4, bias 3) accumulator datapath:
// format constants, the controller state encoding and the unpacked operand.
package fp8_pkg;

    localparam int         EXP_W    = 3;
    localparam int         MAN_W    = 4;
    localparam int         BIAS     = 3;
    localparam logic [7:0] FP8_ZERO = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    // Unpacked operand: mant carries the implicit leading one, so it is
    // MAN_W+1 bits wide. Zero operands are held as +0 with a cleared mantissa.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   mant;
        logic             is_zero;
    } fp8_op_t;

    localparam fp8_op_t FP8_OP_ZERO = '{sign: 1'b0, exp: 3'd0, mant: 5'd0, is_zero: 1'b1};

    // Decode an FP8 byte; both 0x00 and 0x80 decode to +0.
    function automatic fp8_op_t fp8_unpack(input logic [7:0] v);
        fp8_op_t r;
        r.is_zero = (v[6:0] == 7'd0);
        if (r.is_zero) begin
            r.sign = 1'b0;
            r.exp  = 3'd0;
            r.mant = 5'd0;
        end else begin
            r.sign = v[7];
            r.exp  = v[6:4];
            r.mant = {1'b1, v[3:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/fp8_normalize.sv
// Combinational normaliser: turns a 6-bit aligned magnitude (bit 5 is the
// carry of the add) plus the common exponent into a packed FP8 value.
// Truncates, flushes underflow to +0 and saturates overflow.
module fp8_normalize
    import fp8_pkg::*;
(
    input  logic [5:0] mag,
    input  logic [2:0] exp,
    input  logic       sign,
    output logic [7:0] result,
    output logic       ovf
);

    logic [2:0] lzc_s;
    logic [4:0] exp_ext_s;   // two's complement, spans -4 .. +8
    logic [3:0] frac_s;

    // Leading-zero count of the non-carry part of the magnitude
    always_comb begin
        lzc_s = 3'd0;
        casez (mag[4:0])
            5'b1????: lzc_s = 3'd0;
            5'b01???: lzc_s = 3'd1;
            5'b001??: lzc_s = 3'd2;
            5'b0001?: lzc_s = 3'd3;
            5'b00001: lzc_s = 3'd4;
            default:  lzc_s = 3'd0;
        endcase
    end

    // Shift the mantissa into place, adjust the exponent, then clamp
    always_comb begin
        result    = FP8_ZERO;
        ovf       = 1'b0;
        frac_s    = 4'd0;
        exp_ext_s = 5'd0;
        if (mag[5]) begin
            frac_s    = mag[4:1];
            exp_ext_s = {2'b00, exp} + 5'd1;
        end else begin
            // The leading one lands on bit 4 and drops off the 4-bit fraction
            frac_s    = mag[3:0] << lzc_s;
            exp_ext_s = {2'b00, exp} - {2'b00, lzc_s};
        end

        if (mag == 6'd0) begin
            result = FP8_ZERO;
        end else if (exp_ext_s[4]) begin
            result = FP8_ZERO;
        end else if (exp_ext_s > 5'd7) begin
            result = {sign, 3'b111, 4'b1111};
            ovf    = 1'b1;
        end else begin
            result = {sign, exp_ext_s[2:0], frac_s};
        end
    end

endmodule

// File: rtl/fp8_accumulator.sv
// Multi-cycle FP8 accumulator. Each accepted product walks through
// ALIGN -> ADD -> NORM (one operand per four cycles); the operand flagged
// last hands the group total to a held output handshake in OUT.
module fp8_accumulator
    import fp8_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       ovf
);

    state_e           state_r;
    state_e           state_next_s;

    fp8_op_t          acc_r;
    fp8_op_t          op_r;
    logic             last_r;

    logic             big_sign_s;
    logic [EXP_W-1:0] big_exp_s;
    logic [MAN_W:0]   big_mant_s;
    logic             small_sign_s;
    logic [MAN_W:0]   small_mant_s;
    logic [EXP_W-1:0] exp_diff_s;

    logic             big_sign_r;
    logic [EXP_W-1:0] big_exp_r;
    logic [MAN_W:0]   big_mant_r;
    logic             small_sign_r;
    logic [MAN_W:0]   small_mant_r;

    logic [MAN_W+1:0] sum_mag_s;
    logic             sum_sign_s;
    logic [MAN_W+1:0] sum_mag_r;
    logic             sum_sign_r;

    logic [7:0]       norm_result_s;
    logic             norm_ovf_s;

    logic             in_ready_s;
    logic             out_valid_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [7:0]       out_data_r;
    logic             ovf_r;

    logic             in_fire_s;
    logic             out_fire_s;

    // in_ready_r mirrors state IDLE, so it doubles as the accept qualifier
    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign ovf       = ovf_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_fire_s) begin
                    state_next_s = ST_ALIGN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ALIGN: state_next_s = ST_ADD;
            ST_ADD:   state_next_s = ST_NORM;
            ST_NORM: begin
                if (last_r) begin
                    state_next_s = ST_OUT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (out_fire_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OUT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the upcoming state so they register in step with it
    always_comb begin
        in_ready_s  = (state_next_s == ST_IDLE);
        out_valid_s = (state_next_s == ST_OUT);
    end

    // Alignment: the larger-exponent operand stays put, the other is shifted down
    always_comb begin
        big_sign_s   = acc_r.sign;
        big_exp_s    = acc_r.exp;
        big_mant_s   = acc_r.mant;
        small_sign_s = 1'b0;
        small_mant_s = 5'd0;
        exp_diff_s   = 3'd0;
        if (op_r.is_zero) begin
            big_sign_s = acc_r.sign;
            big_exp_s  = acc_r.exp;
            big_mant_s = acc_r.mant;
        end else if (acc_r.is_zero) begin
            big_sign_s = op_r.sign;
            big_exp_s  = op_r.exp;
            big_mant_s = op_r.mant;
        end else if (acc_r.exp >= op_r.exp) begin
            exp_diff_s   = acc_r.exp - op_r.exp;
            big_sign_s   = acc_r.sign;
            big_exp_s    = acc_r.exp;
            big_mant_s   = acc_r.mant;
            small_sign_s = op_r.sign;
            if (exp_diff_s >= 3'd5) begin
                small_mant_s = 5'd0;
            end else begin
                small_mant_s = op_r.mant >> exp_diff_s;
            end
        end else begin
            exp_diff_s   = op_r.exp - acc_r.exp;
            big_sign_s   = op_r.sign;
            big_exp_s    = op_r.exp;
            big_mant_s   = op_r.mant;
            small_sign_s = acc_r.sign;
            if (exp_diff_s >= 3'd5) begin
                small_mant_s = 5'd0;
            end else begin
                small_mant_s = acc_r.mant >> exp_diff_s;
            end
        end
    end

    // Signed-magnitude add. When exponents differ the shifted mantissa is
    // always below the unshifted one, so a mantissa compare alone picks the
    // larger magnitude.
    always_comb begin
        sum_mag_s  = 6'd0;
        sum_sign_s = big_sign_r;
        if (big_sign_r == small_sign_r) begin
            sum_mag_s  = {1'b0, big_mant_r} + {1'b0, small_mant_r};
            sum_sign_s = big_sign_r;
        end else if (big_mant_r >= small_mant_r) begin
            sum_mag_s  = {1'b0, big_mant_r} - {1'b0, small_mant_r};
            sum_sign_s = big_sign_r;
        end else begin
            sum_mag_s  = {1'b0, small_mant_r} - {1'b0, big_mant_r};
            sum_sign_s = small_sign_r;
        end
    end

    fp8_normalize u_normalize (
        .mag    (sum_mag_r),
        .exp    (big_exp_r),
        .sign   (sum_sign_r),
        .result (norm_result_s),
        .ovf    (norm_ovf_s)
    );

    // Datapath pipeline registers and the accumulator itself
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r        <= FP8_OP_ZERO;
            op_r         <= FP8_OP_ZERO;
            last_r       <= 1'b0;
            big_sign_r   <= 1'b0;
            big_exp_r    <= 3'd0;
            big_mant_r   <= 5'd0;
            small_sign_r <= 1'b0;
            small_mant_r <= 5'd0;
            sum_mag_r    <= 6'd0;
            sum_sign_r   <= 1'b0;
        end else begin
            if (in_fire_s) begin
                op_r   <= fp8_unpack(in_data);
                last_r <= in_last;
            end
            if (state_r == ST_ALIGN) begin
                big_sign_r   <= big_sign_s;
                big_exp_r    <= big_exp_s;
                big_mant_r   <= big_mant_s;
                small_sign_r <= small_sign_s;
                small_mant_r <= small_mant_s;
            end
            if (state_r == ST_ADD) begin
                sum_mag_r  <= sum_mag_s;
                sum_sign_r <= sum_sign_s;
            end
            // A saturated group freezes the accumulator until the output is taken
            if (out_fire_s) begin
                acc_r <= FP8_OP_ZERO;
            end else if ((state_r == ST_NORM) && !ovf_r) begin
                acc_r <= fp8_unpack(norm_result_s);
            end
        end
    end

    // Registered handshake, result and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= FP8_ZERO;
            ovf_r       <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            if (out_fire_s) begin
                out_data_r <= FP8_ZERO;
                ovf_r      <= 1'b0;
            end else if (state_r == ST_NORM) begin
                ovf_r <= ovf_r | norm_ovf_s;
                if (last_r) begin
                    out_data_r <= ovf_r ? {acc_r.sign, 7'h7F} : norm_result_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp8_accumulator.sv
// Self-checking bench for fp8_accumulator: directed groups with known sums,
// handshake timing, output hold, mid-group reset, then random groups checked
// against a real-valued reference model of truncating FP8 accumulation.
module tb_fp8_accumulator;
    import fp8_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       ovf;

    int         n_tests = 0;
    int         n_fail  = 0;

    logic [7:0] grp [8];
    int         grp_n;

    always #5 clk = ~clk;

    fp8_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) begin
            for (int i = 0; i < k; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -k; i++) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic real fp8_real(input logic [7:0] v);
        real m;
        if (v[6:0] == 7'd0) return 0.0;
        m = real'(16 + int'(v[3:0])) * pow2(int'(v[6:4]) - BIAS - MAN_W);
        return v[7] ? -m : m;
    endfunction

    function automatic real trunc_grid(input real x, input real ulp);
        if (x >= 0.0) return $floor(x / ulp) * ulp;
        return -($floor(-x / ulp) * ulp);
    endfunction

    // One accumulation step: {ovf, result}
    function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b);
        real        va, vb, ulp, s, m;
        int         ea, eb, e, mant;
        logic       sgn;
        if (b[6:0] == 7'd0) return {1'b0, a};
        if (a[6:0] == 7'd0) return {1'b0, b};
        ea  = int'(a[6:4]);
        eb  = int'(b[6:4]);
        ulp = pow2(((ea > eb) ? ea : eb) - BIAS - MAN_W);
        // both values are snapped toward zero onto the larger operand's grid
        va  = trunc_grid(fp8_real(a), ulp);
        vb  = trunc_grid(fp8_real(b), ulp);
        s   = va + vb;
        sgn = (s < 0.0);
        m   = sgn ? -s : s;
        if (m == 0.0) return 9'h000;
        e = -1;
        for (int k = 8; k >= 0; k--) begin
            if (e < 0 && m >= pow2(k - BIAS)) e = k;
        end
        if (e < 0) return 9'h000;
        if (e > 7) return {1'b1, sgn, 7'h7F};
        mant = int'($floor(m / pow2(e - BIAS - MAN_W)));
        return {1'b0, sgn, e[2:0], mant[3:0]};
    endfunction

    function automatic logic [8:0] model_group();
        logic [7:0] acc;
        logic       o;
        logic [8:0] r;
        acc = 8'h00;
        o   = 1'b0;
        for (int i = 0; i < grp_n; i++) begin
            if (!o) begin
                r   = ref_add(acc, grp[i]);
                acc = r[7:0];
                o   = r[8];
            end
        end
        return {o, acc};
    endfunction

    task automatic set_grp(input int n, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        grp_n  = n;
        grp[0] = a;
        grp[1] = b;
        grp[2] = c;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] d, input logic l);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_wait", 32'(guard < 50), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 1;
        while (!in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_group(input logic [7:0] exp_d, input logic exp_o, input logic check_lat, input int hold);
        int         lat;
        logic [7:0] held;
        for (int i = 0; i < grp_n; i++) begin
            send(grp[i], (i == grp_n - 1));
            if (i < grp_n - 1) begin
                if (check_lat) begin
                    chk("ready_low_after_accept", 32'(in_ready), 32'd0);
                    wait_ready(lat);
                    chk("ready_latency", 32'(lat), 32'd4);
                end else begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        end
        wait_out(lat);
        if (check_lat) begin
            chk("out_latency", 32'(lat), 32'd4);
        end else begin
            chk("out_timeout", 32'(lat < 50), 32'd1);
        end
        chk("out_data", 32'(out_data), 32'(exp_d));
        chk("ovf", 32'(ovf), 32'(exp_o));
        held = out_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(held));
            chk("hold_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk("ready_after_out", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [8:0] m;
        int         lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        set_grp(2, 8'h30, 8'h30, 8'h00); run_group(8'h40, 1'b0, 1'b1, 0);
        set_grp(2, 8'h30, 8'h10, 8'h00); run_group(8'h34, 1'b0, 1'b1, 0);
        set_grp(2, 8'h38, 8'h38, 8'h00); run_group(8'h48, 1'b0, 1'b1, 0);
        set_grp(2, 8'h30, 8'hB0, 8'h00); run_group(8'h00, 1'b0, 1'b1, 0);
        set_grp(1, 8'h00, 8'h00, 8'h00); run_group(8'h00, 1'b0, 1'b1, 0);
        set_grp(1, 8'hB4, 8'h00, 8'h00); run_group(8'hB4, 1'b0, 1'b1, 0);
        set_grp(2, 8'h60, 8'h60, 8'h00); run_group(8'h70, 1'b0, 1'b1, 0);
        set_grp(3, 8'h70, 8'h70, 8'hB0); run_group(8'h7F, 1'b1, 1'b1, 2);
        set_grp(2, 8'h30, 8'h30, 8'h00); run_group(8'h40, 1'b0, 1'b1, 5);
        set_grp(1, 8'h30, 8'h00, 8'h00); run_group(8'h30, 1'b0, 1'b1, 0);

        // Reset lands while the second operand is in ADD
        send(8'h30, 1'b0);
        wait_ready(lat);
        send(8'h30, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'h00);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        set_grp(1, 8'h30, 8'h00, 8'h00); run_group(8'h30, 1'b0, 1'b1, 0);

        for (int g = 0; g < 60; g++) begin
            grp_n = int'($urandom_range(1, 5));
            for (int i = 0; i < grp_n; i++) begin
                grp[i] = 8'($urandom_range(0, 255));
            end
            m = model_group();
            run_group(m[7:0], m[8], 1'b0, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
